mem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer in front of the unified 4-clock memory. Shares the

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter_rr2.sv | 28 ++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types for the two-port memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  localparam int MEM_LAT = 4;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Requester and memory-side bus of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdy;
  logic              busy;
  logic              err_timeout;

  // Arbiter view
  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
    output i_rdata, i_done, d_rdata, d_done, mem_addr, mem_re, mem_we,
           mem_wdata, busy, err_timeout
  );

  // Requesters plus memory view
  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
    input  i_rdata, i_done, d_rdata, d_done, mem_addr, mem_re, mem_we,
           mem_wdata, busy, err_timeout
  );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_rr2.sv
// ============================================================================
// Module      : arb_rr2
// Description : Two-way round-robin picker; favours the side not granted last.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  gnt_e last_gnt,
  output gnt_e gnt
);

  always_comb begin
    gnt = GNT_I;
    if (req_i && req_d) begin
      gnt = (last_gnt == GNT_I) ? GNT_D : GNT_I;
    end else if (req_d) begin
      gnt = GNT_D;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one memory port between I-cache fills and D-cache
//               accesses; one-cycle strobes, held addr/wdata, timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int TO_CYC = 15
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  localparam logic [7:0] c_to_cyc = 8'(TO_CYC);

  state_e            state_q;
  gnt_e              gnt_q;
  gnt_e              last_gnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [7:0]        to_cnt_q;
  logic [7:0]        to_cnt_d;
  logic              i_done_q;
  logic              d_done_q;
  logic              err_q;

  gnt_e              w_gnt;
  logic              w_any;
  logic              w_issue;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  arb_rr2 u_rr (
    .req_i    (bus.i_req),
    .req_d    (bus.d_req),
    .last_gnt (last_gnt_q),
    .gnt      (w_gnt)
  );

  // The issue cycle is the IDLE cycle itself; rst gating keeps strobes low
  // while reset is held even if a request is already pending.
  assign w_any       = bus.i_req | bus.d_req;
  assign w_issue     = (state_q == IDLE) && w_any && !rst;
  assign w_win_we    = (w_gnt == GNT_D) && bus.d_we;
  assign w_win_addr  = (w_gnt == GNT_D) ? bus.d_addr : bus.i_addr;
  assign w_win_wdata = (w_gnt == GNT_D) ? bus.d_wdata : '0;
  assign to_cnt_d    = to_cnt_q + 8'd1;

  assign bus.mem_re      = w_issue && !w_win_we;
  assign bus.mem_we      = w_issue && w_win_we;
  assign bus.mem_addr    = w_issue ? w_win_addr  : addr_q;
  assign bus.mem_wdata   = w_issue ? w_win_wdata : wdata_q;
  assign bus.i_rdata     = i_rdata_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.i_done      = i_done_q;
  assign bus.d_done      = d_done_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.err_timeout = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_I;
      last_gnt_q <= GNT_I;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      to_cnt_q   <= 8'd0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_any) begin
            gnt_q      <= w_gnt;
            last_gnt_q <= w_gnt;
            we_q       <= w_win_we;
            addr_q     <= w_win_addr;
            wdata_q    <= w_win_wdata;
            to_cnt_q   <= 8'd0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          to_cnt_q <= to_cnt_d;
          if (bus.mem_rdy) begin
            if (!we_q) begin
              if (gnt_q == GNT_I) i_rdata_q <= bus.mem_rdata;
              else                d_rdata_q <= bus.mem_rdata;
            end
            i_done_q <= (gnt_q == GNT_I);
            d_done_q <= (gnt_q == GNT_D);
            state_q  <= DONE;
          end else if (to_cnt_d == c_to_cyc) begin
            // A timed-out read returns zero; a timed-out write touches nothing.
            err_q <= 1'b1;
            if (!we_q) begin
              if (gnt_q == GNT_I) i_rdata_q <= '0;
              else                d_rdata_q <= '0;
            end
            i_done_q <= (gnt_q == GNT_I);
            d_done_q <= (gnt_q == GNT_D);
            state_q  <= DONE;
          end
        end
        DONE: begin
          i_done_q <= 1'b0;
          d_done_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench: memory model, transaction-level arbiter
//               model compared every cycle, directed and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int TO_CYC = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TO_CYC(TO_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [31:0] mem_store [int];
  logic [31:0] ref_mem   [int];

  function automatic logic [31:0] dflt(input int a);
    return {16'(a) ^ 16'h5A5A, 16'(a)};
  endfunction

  function automatic logic [31:0] mem_rd(input int a);
    return mem_store.exists(a) ? mem_store[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic preload(input int a, input logic [31:0] v);
    mem_store[a] = v;
    ref_mem[a]   = v;
  endtask

  // ---------------- memory model ----------------
  bit          pend     = 0;
  int          cd       = 0;
  int          lat      = 3;
  bit          rand_lat = 0;
  bit          never    = 0;
  bit          noise    = 0;
  logic [31:0] p_data   = '0;
  int          re_cnt   = 0;
  int          we_cnt   = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (bus.mem_re || bus.mem_we)) begin
        if (bus.mem_re) re_cnt++;
        if (bus.mem_we) begin
          we_cnt++;
          mem_store[int'(bus.mem_addr)] = bus.mem_wdata;
        end
        p_data = mem_rd(int'(bus.mem_addr));
        pend   = 1;
        cd     = rand_lat ? int'($urandom_range(1, 6)) : lat;
      end
    end
  end

  initial begin
    bus.mem_rdy   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pend        = 0;
        bus.mem_rdy = 1'b0;
      end else if (pend) begin
        if (!never) cd--;
        if (!never && cd <= 0) begin
          bus.mem_rdy   = 1'b1;
          bus.mem_rdata = p_data;
          pend          = 0;
        end else begin
          bus.mem_rdy   = 1'b0;
          bus.mem_rdata = $urandom;
        end
      end else begin
        bus.mem_rdy   = noise ? 1'($urandom % 2) : 1'b0;
        bus.mem_rdata = $urandom;
      end
    end
  end

  // ---------------- transaction-level arbiter model ----------------
  bit          m_act = 0, m_side = 0, m_last = 0, m_we = 0, m_to = 0;
  int          m_start = 0, m_end = -1;
  logic [15:0] m_addr = '0;
  logic [31:0] m_wdata = '0, m_exp = '0;
  logic [31:0] e_ir = '0, e_dr = '0;
  bit          e_err = 0;
  bit          ere, ewe, eid, edd, ebusy;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        m_act = 0; m_last = 0; m_end = -1;
        e_ir = '0; e_dr = '0; e_err = 0;
        check("rst_mem_re", 32'(bus.mem_re), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_done",   32'({bus.i_done, bus.d_done}), 32'd0);
        check("rst_rdata",  bus.i_rdata | bus.d_rdata, 32'd0);
        check("rst_err",    32'(bus.err_timeout), 32'd0);
      end else begin
        ere = 0; ewe = 0; eid = 0; edd = 0; ebusy = 0;
        if (m_act && m_end >= 0 && cyc == m_end + 1) begin
          ebusy = 1;
          if (m_to) e_err = 1;
          if (!m_we) begin
            if (m_side) e_dr = m_to ? '0 : m_exp;
            else        e_ir = m_to ? '0 : m_exp;
          end
          if (m_side) edd = 1; else eid = 1;
          m_act = 0;
        end else if (m_act) begin
          ebusy = 1;
          check("hold_addr",  32'(bus.mem_addr), 32'(m_addr));
          check("hold_wdata", bus.mem_wdata, m_wdata);
          if (bus.mem_rdy) begin
            m_end = cyc; m_to = 0;
          end else if (cyc - m_start == TO_CYC) begin
            m_end = cyc; m_to = 1;
          end
        end else if (bus.i_req || bus.d_req) begin
          m_side  = (bus.i_req && bus.d_req) ? !m_last : bus.d_req;
          m_act   = 1;
          m_start = cyc;
          m_end   = -1;
          m_we    = m_side && bus.d_we;
          m_addr  = m_side ? bus.d_addr : bus.i_addr;
          m_wdata = m_side ? bus.d_wdata : '0;
          if (m_we) ref_mem[int'(m_addr)] = m_wdata;
          else      m_exp = ref_rd(int'(m_addr));
          m_last = m_side;
          ere    = !m_we;
          ewe    = m_we;
          check("issue_addr",  32'(bus.mem_addr), 32'(m_addr));
          check("issue_wdata", bus.mem_wdata, m_wdata);
        end
        check("mem_re",  32'(bus.mem_re), 32'(ere));
        check("mem_we",  32'(bus.mem_we), 32'(ewe));
        check("busy",    32'(bus.busy),   32'(ebusy));
        check("i_done",  32'(bus.i_done), 32'(eid));
        check("d_done",  32'(bus.d_done), 32'(edd));
        check("i_rdata", bus.i_rdata, e_ir);
        check("d_rdata", bus.d_rdata, e_dr);
        check("err_timeout", 32'(bus.err_timeout), 32'(e_err));
      end
    end
  end

  // ---------------- requesters ----------------
  task automatic do_i(input logic [15:0] a, output int n);
    bus.i_req  = 1'b1;
    bus.i_addr = a;
    n = 0;
    while (n < 60 && !bus.i_done) begin
      @(posedge clk); #1; n++;
    end
    check("i_done_seen", 32'(bus.i_done), 32'd1);
    bus.i_req  = 1'b0;
    bus.i_addr = 16'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic do_d(input logic we, input logic [15:0] a, input logic [31:0] wd, output int n);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    n = 0;
    while (n < 60 && !bus.d_done) begin
      @(posedge clk); #1; n++;
    end
    check("d_done_seen", 32'(bus.d_done), 32'd1);
    bus.d_req   = 1'b0;
    bus.d_we    = 1'($urandom % 2);
    bus.d_addr  = 16'($urandom);
    bus.d_wdata = $urandom;
    @(posedge clk); #1;
  endtask

  task automatic i_driver(input int cnt);
    int n, gap;
    for (int k = 0; k < cnt; k++) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin @(posedge clk); #1; end
      do_i(16'($urandom_range(0, 31)), n);
    end
  endtask

  task automatic d_driver(input int cnt);
    int n, gap;
    for (int k = 0; k < cnt; k++) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin @(posedge clk); #1; end
      do_d(1'($urandom % 2), 16'($urandom_range(0, 31)), $urandom, n);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  int n1, n2, r0, w0;

  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_busy",  32'(bus.busy), 32'd0);
    check("reset_irdat", bus.i_rdata, 32'd0);
    check("reset_err",   32'(bus.err_timeout), 32'd0);

    preload(16'h0100, 32'h11112222);
    preload(16'h0400, 32'h0BADCAFE);
    preload(16'h0010, 32'hBEEF1234);
    preload(16'h0300, 32'h13579BDF);

    // Simultaneous requests after reset: D first, I five cycles later
    fork
      do_i(16'h0100, n1);
      do_d(1'b0, 16'h0400, 32'h0, n2);
    join
    check("t3_d_lat", 32'(n2), 32'd4);
    check("t3_i_lat", 32'(n1), 32'd9);
    check("t3_i_rd",  bus.i_rdata, 32'h11112222);
    check("t3_d_rd",  bus.d_rdata, 32'h0BADCAFE);
    fork
      do_i(16'h0100, n1);
      do_d(1'b0, 16'h0400, 32'h0, n2);
    join
    check("t3b_d_lat", 32'(n2), 32'd4);
    check("t3b_i_lat", 32'(n1), 32'd9);

    // Single I read
    r0 = re_cnt;
    do_i(16'h0010, n1);
    check("t1_lat",   32'(n1), 32'd4);
    check("t1_rdata", bus.i_rdata, 32'hBEEF1234);
    check("t1_re_n",  32'(re_cnt - r0), 32'd1);

    // D write leaves d_rdata alone
    w0 = we_cnt;
    do_d(1'b1, 16'h0200, 32'hCAFEF00D, n2);
    check("t2_lat",   32'(n2), 32'd4);
    check("t2_we_n",  32'(we_cnt - w0), 32'd1);
    check("t2_mem",   mem_store[32'h0200], 32'hCAFEF00D);
    check("t2_drd",   bus.d_rdata, 32'h0BADCAFE);

    // Back-to-back I reads
    r0 = re_cnt;
    do_i(16'h0000, n1);
    do_i(16'h0002, n2);
    check("t6_lat1",  32'(n1), 32'd4);
    check("t6_lat2",  32'(n2), 32'd4);
    check("t6_re_n",  32'(re_cnt - r0), 32'd2);
    check("t6_rdata", bus.i_rdata, dflt(2));

    // Memory never ready
    never = 1;
    do_i(16'h0040, n1);
    check("t4_lat",   32'(n1), 32'd16);
    check("t4_rdata", bus.i_rdata, 32'd0);
    check("t4_err",   32'(bus.err_timeout), 32'd1);
    repeat (5) @(posedge clk);
    #1 check("t4_sticky", 32'(bus.err_timeout), 32'd1);
    never = 0;

    // Reset during WAIT of a D read
    fork
      do_d(1'b0, 16'h0300, 32'h0, n2);
      begin
        @(posedge clk); @(posedge clk); #2;
        check("t5_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_re",   32'(bus.mem_re), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_done", 32'(bus.d_done), 32'd0);
        check("t5_addr", 32'(bus.mem_addr), 32'd0);
        check("t5_err",  32'(bus.err_timeout), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
      end
    join
    check("t5_rdata", bus.d_rdata, 32'h13579BDF);

    // Random concurrent traffic
    rand_lat = 1;
    noise    = 1;
    fork
      i_driver(40);
      d_driver(40);
    join
    repeat (4) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
